traffic_sample_sched: RTL and testbench
=======================================

# traffic_sample_sched

Measurement scheduler for the diagnosis-system traffic monitor. It runs programmable measurement windows on demand. In each window it counts NoC flit-valid cycles and measures the interval between global events. It buffers the resulting samples in a small FIFO and drains them over a valid/ready stream toward the debug packetizer. Drops are accounted for in a saturating overflow counter, and a stop command flushes a final partial window before returning to idle.

## Interface
- FIFO_DEPTH, 8, sample FIFO entries; power of two, at least 2
- clk  in  1  single clock domain
- rst  in  1  reset, asynchronous, active-high
- cfg_window  in  16  window length in cycles; sampled on accepted start
- cfg_start  in  1  one-cycle pulse, starts measurement
- cfg_stop  in  1  one-cycle pulse, ends measurement
- event_global  in  1  global event strobe
- flit_valid  in  1  NoC flit-valid observation
- out_valid  out  1  sample available
- out_ready  in  1  consumer accepts sample
- out_type  out  1  0 = flit-count sample, 1 = event-interval sample
- out_data  out  32  sample value
- busy  out  1  high whenever state is not IDLE
- overflow_cnt  out  8  dropped samples, saturating at 255

## Operation
- States: IDLE, ARM, RUN, FLUSH.
- IDLE:
  - cfg_start with cfg_window != 0 latches the window length and goes to ARM.
  - cfg_start with cfg_window == 0 is ignored.
  - cfg_stop is ignored.
- ARM (one cycle):
  - wcnt = 1, flit_cnt = 0, ev_cnt = 1, overflow_cnt = 0, pending cleared.
  - Next state is RUN; cfg_stop during ARM goes to IDLE instead.
- RUN, every cycle:
  - wcnt increments.
  - ev_cnt increments, saturating at 0xFFFF_FFFF.
  - flit_cnt increments when flit_valid is high.
- Window end (RUN and wcnt == window):
  - Raises candidate W with value flit_cnt + flit_valid, zero-extended to 32 bits.
  - Then flit_cnt = 0 and wcnt = 1.
- Event (RUN and event_global):
  - Raises candidate E with value ev_cnt; then ev_cnt = 1.
- cfg_start in any state other than IDLE is ignored.
- cfg_stop in RUN: that cycle is processed normally, then the block enters FLUSH.
- FLUSH:
  - On the first FLUSH cycle, raises W with value flit_cnt if wcnt > 1; otherwise no candidate.
  - event_global and flit_valid are ignored.
  - Goes to IDLE once pending is empty, the FIFO is empty, and the first cycle is done.
- Sample arbitration each cycle, candidate order P (pending register, 1 entry), W, E:
  - FIFO not full: the first present candidate is written to the FIFO, the second goes to pending, and any third is dropped.
  - FIFO full: P stays in pending, W and E are dropped.
  - Each dropped sample increments overflow_cnt (saturating).
  - Fullness is judged on the occupancy at the start of the cycle; a same-cycle pop does not free space.
- FIFO: show-ahead; out_type/out_data show the head entry; pop when out_valid && out_ready.
- Width rules:
  - flit_cnt is 16 bits and cannot overflow, since window ≤ 65535.
  - ev_cnt saturates and never wraps.
  - FIFO pointers carry one extra bit to tell full from empty.

## Timing
- Reset values: out_valid 0, out_type 0, out_data 0, busy 0, overflow_cnt 0, state IDLE, FIFO empty, pending empty.
- Reset takes effect immediately; rst asserted mid-RUN or mid-FLUSH discards all samples.
- busy rises in the cycle after an accepted cfg_start.
- A sample written in cycle N shows out_valid = 1 in cycle N+1, provided the FIFO was empty.
- out_valid never drops without a pop, and out_type/out_data stay stable while out_valid && !out_ready.
- Back-to-back pops: one sample per cycle while out_ready is held high.
- A pending entry reaches the FIFO no earlier than the cycle after it was captured.
- busy falls in the cycle after FLUSH exits.

## Test plan
- Window counts: window = 4, flit_valid always high, out_ready = 1, no events → type-0 samples of value 4, one every 4 cycles after ARM.
- Event interval: event_global pulsed 10 cycles after ARM and then 3 cycles later, window = 1000 → type-1 samples 10, then 3.
- Simultaneous window end and event:
  - Setup: window = 5, event on the window-end cycle.
  - Required: W is written first and E one cycle later.
  - Required: with out_ready low, a third candidate in the next cycle is dropped and overflow_cnt = 1.
- Full FIFO: out_ready held low, window = 2, run 40 cycles → FIFO_DEPTH samples are retained; overflow_cnt counts the rest; the first popped sample equals the first written.
- Stop and flush: window = 100, flit_valid high for 7 RUN cycles, then cfg_stop → final type-0 sample of 7; busy stays high until the FIFO drains, then returns to 0.
- Reset mid-RUN: rst asserted with 3 samples queued → out_valid and busy go low immediately; after release the block is in IDLE and cfg_start with cfg_window == 0 has no effect.

Source files
------------

// File: rtl/traffic_sample_sched.sv
// Measurement scheduler: counts flit-valid cycles per window and global-event intervals,
// queues samples in a show-ahead FIFO drained over a valid/ready stream.
module traffic_sample_sched #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_window,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic        event_global,
  input  logic        flit_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_type,
  output logic [31:0] out_data,
  output logic        busy,
  output logic [7:0]  overflow_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StFlush} state_e;

  typedef struct packed {
    logic        typ;
    logic [31:0] data;
  } sample_t;

  state_e        state_q, state_d;
  logic [15:0]   window_q, window_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [15:0]   flit_cnt_q, flit_cnt_d;
  logic [31:0]   ev_cnt_q, ev_cnt_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          pend_vld_q, pend_vld_d;
  sample_t       pend_q, pend_d;
  logic          first_q, first_d;
  logic [AW:0]   wptr_q, rptr_q;
  sample_t       mem_q [FIFO_DEPTH];

  logic          fifo_empty, fifo_full, pop, push;
  sample_t       push_smp;
  logic          w_vld, e_vld;
  sample_t       w_smp, e_smp;
  logic [1:0]    drops;
  logic [8:0]    ovf_sum;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = !fifo_empty && out_ready;

  assign out_valid    = !fifo_empty;
  assign out_type     = fifo_empty ? 1'b0 : mem_q[rptr_q[AW-1:0]].typ;
  assign out_data     = fifo_empty ? 32'd0 : mem_q[rptr_q[AW-1:0]].data;
  assign busy         = (state_q != StIdle);
  assign overflow_cnt = ovf_q;

  // Candidate samples raised this cycle.
  always_comb begin
    w_vld = 1'b0;
    e_vld = 1'b0;
    w_smp = '0;
    e_smp = '0;
    if (state_q == StRun) begin
      w_vld = (wcnt_q == window_q);
      w_smp = '{typ: 1'b0, data: {16'd0, flit_cnt_q + {15'd0, flit_valid}}};
      e_vld = event_global;
      e_smp = '{typ: 1'b1, data: ev_cnt_q};
    end else if (state_q == StFlush) begin
      w_vld = first_q && (wcnt_q > 16'd1);
      w_smp = '{typ: 1'b0, data: {16'd0, flit_cnt_q}};
    end
  end

  // Arbitration in order pending, window, event; fullness uses start-of-cycle occupancy.
  always_comb begin
    push       = 1'b0;
    push_smp   = '0;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    drops      = 2'd0;
    if (!fifo_full) begin
      if (pend_vld_q) begin
        push       = 1'b1;
        push_smp   = pend_q;
        pend_vld_d = 1'b0;
        if (w_vld) begin
          pend_vld_d = 1'b1;
          pend_d     = w_smp;
          if (e_vld) drops = 2'd1;
        end else if (e_vld) begin
          pend_vld_d = 1'b1;
          pend_d     = e_smp;
        end
      end else if (w_vld) begin
        push     = 1'b1;
        push_smp = w_smp;
        if (e_vld) begin
          pend_vld_d = 1'b1;
          pend_d     = e_smp;
        end
      end else if (e_vld) begin
        push     = 1'b1;
        push_smp = e_smp;
      end
    end else begin
      drops = {1'b0, w_vld} + {1'b0, e_vld};
    end
    ovf_sum = {1'b0, ovf_q} + {7'd0, drops};
    ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    if (state_q == StArm) begin
      pend_vld_d = 1'b0;
      ovf_d      = 8'd0;
    end
  end

  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    wcnt_d     = wcnt_q;
    flit_cnt_d = flit_cnt_q;
    ev_cnt_d   = ev_cnt_q;
    first_d    = first_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_start && (cfg_window != 16'd0)) begin
          window_d = cfg_window;
          state_d  = StArm;
        end
      end
      StArm: begin
        wcnt_d     = 16'd1;
        flit_cnt_d = 16'd0;
        ev_cnt_d   = 32'd1;
        state_d    = cfg_stop ? StIdle : StRun;
      end
      StRun: begin
        if (w_vld) begin
          wcnt_d     = 16'd1;
          flit_cnt_d = 16'd0;
        end else begin
          wcnt_d     = wcnt_q + 16'd1;
          flit_cnt_d = flit_cnt_q + {15'd0, flit_valid};
        end
        if (event_global)                ev_cnt_d = 32'd1;
        else if (ev_cnt_q != 32'hFFFF_FFFF) ev_cnt_d = ev_cnt_q + 32'd1;
        if (cfg_stop) begin
          state_d = StFlush;
          first_d = 1'b1;
        end
      end
      StFlush: begin
        first_d = 1'b0;
        if (!first_q && !pend_vld_q && fifo_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      window_q   <= 16'd0;
      wcnt_q     <= 16'd0;
      flit_cnt_q <= 16'd0;
      ev_cnt_q   <= 32'd0;
      ovf_q      <= 8'd0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      first_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      wcnt_q     <= wcnt_d;
      flit_cnt_q <= flit_cnt_d;
      ev_cnt_q   <= ev_cnt_d;
      ovf_q      <= ovf_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      first_q    <= first_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= push_smp;
  end

endmodule

// File: tb/tb_traffic_sample_sched.sv
// Scoreboard bench for traffic_sample_sched: directed scenarios push expected samples,
// a negedge monitor pops and compares on every accepted output.
module tb_traffic_sample_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_window;
  logic        cfg_start, cfg_stop, event_global, flit_valid, out_ready;
  logic        out_valid, out_type, busy;
  logic [31:0] out_data;
  logic [7:0]  overflow_cnt;

  typedef struct packed {
    logic        typ;
    logic [31:0] data;
  } smp_t;

  smp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  traffic_sample_sched #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_window   (cfg_window),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .event_global (event_global),
    .flit_valid   (flit_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_type     (out_type),
    .out_data     (out_data),
    .busy         (busy),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic t, input int d);
    exp_q.push_back('{typ: t, data: d});
  endtask

  // Leaves the bench in the first RUN cycle.
  task automatic start(input int w);
    cfg_window = 16'(w);
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
    check("busy_after_start", busy, 1);
    tick();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int i = 0;
    while (busy && i < bound) begin
      tick();
      i++;
    end
    check(name, busy, 0);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: compares accepted samples and checks head stability while stalled.
  initial begin
    smp_t e;
    smp_t held_s;
    logic held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          n_checks++;
          if (!out_valid || out_type !== held_s.typ || out_data !== held_s.data) begin
            n_errors++;
            $display("FAIL stall_stable: got valid=%0d type=%0d data=%0d, expected valid=1 type=%0d data=%0d",
                     out_valid, out_type, out_data, held_s.typ, held_s.data);
          end
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_sample: got type=%0d data=%0d, expected none",
                     out_type, out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_type !== e.typ || out_data !== e.data) begin
              n_errors++;
              $display("FAIL sample: got type=%0d data=%0d, expected type=%0d data=%0d",
                       out_type, out_data, e.typ, e.data);
            end
          end
        end
        held_v = out_valid && !out_ready;
        held_s = '{typ: out_type, data: out_data};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_window = '0; cfg_start = 0; cfg_stop = 0;
    event_global = 0; flit_valid = 0; out_ready = 0;
    tick(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_type", out_type, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow_cnt, 0);
    rst = 1'b0;
    tick();

    // Stop during ARM returns to idle; stop in IDLE is ignored.
    cfg_stop = 1; tick(); cfg_stop = 0;
    check("idle_stop_ignored", busy, 0);
    cfg_window = 5; cfg_start = 1; tick(); cfg_start = 0;
    check("arm_busy", busy, 1);
    cfg_stop = 1; tick(); cfg_stop = 0;
    check("arm_stop_idle", busy, 0);

    // Window counts: window 4, flits every cycle.
    repeat (3) push_exp(0, 4);
    out_ready = 1; flit_valid = 1;
    start(4);
    tick(11);
    cfg_stop = 1; tick(); cfg_stop = 0; flit_valid = 0;
    wait_idle("t1_idle", 50);

    // Event intervals 10 then 3, plus zero-flit partial window on flush.
    push_exp(1, 10); push_exp(1, 3); push_exp(0, 0);
    start(1000);
    tick(9);
    event_global = 1; tick(); event_global = 0;
    tick(2);
    event_global = 1; tick(); event_global = 0;
    cfg_stop = 1; tick(); cfg_stop = 0;
    wait_idle("t2_idle", 50);
    check("t2_overflow", overflow_cnt, 0);

    // Window end and event together: W first, then E.
    push_exp(0, 5); push_exp(1, 5);
    flit_valid = 1;
    start(5);
    tick(4);
    event_global = 1; cfg_stop = 1; tick(); event_global = 0; cfg_stop = 0;
    wait_idle("t3_idle", 50);

    // Third candidate dropped while FIFO has room.
    push_exp(0, 1); push_exp(0, 1); push_exp(0, 1); push_exp(1, 3); push_exp(0, 1);
    out_ready = 0;
    start(1);
    tick(2);
    event_global = 1; tick();
    cfg_stop = 1; tick(); event_global = 0; cfg_stop = 0;
    tick();
    check("t4_overflow", overflow_cnt, 1);
    check("t4_busy_held", busy, 1);
    out_ready = 1;
    wait_idle("t4_idle", 50);
    check("t4_overflow_kept", overflow_cnt, 1);

    // Full FIFO: 20 windows, 8 kept, 12 dropped; oldest retained.
    push_exp(0, 1);
    repeat (7) push_exp(0, 0);
    out_ready = 0; flit_valid = 1;
    start(2);
    tick(); flit_valid = 0;
    tick(38);
    cfg_stop = 1; tick(); cfg_stop = 0;
    check("t5_overflow", overflow_cnt, 12);
    check("t5_valid", out_valid, 1);
    out_ready = 1;
    wait_idle("t5_idle", 50);
    check("t5_overflow_kept", overflow_cnt, 12);

    // Stop and flush: partial window of 7 flits; busy held until drained.
    push_exp(0, 7);
    out_ready = 0; flit_valid = 1;
    start(100);
    tick(7);
    flit_valid = 0; cfg_stop = 1; tick(); cfg_stop = 0;
    tick(5);
    check("t6_busy_undrained", busy, 1);
    check("t6_valid", out_valid, 1);
    out_ready = 1;
    wait_idle("t6_idle", 50);

    // Reset mid-RUN with queued samples.
    out_ready = 0; flit_valid = 1;
    start(1);
    tick(3);
    check("t7_queued", out_valid, 1);
    rst = 1; #1;
    check("t7_rst_valid", out_valid, 0);
    check("t7_rst_busy", busy, 0);
    tick(); rst = 0; flit_valid = 0;
    cfg_window = 0; cfg_start = 1; tick(); cfg_start = 0;
    tick();
    check("t7_zero_window_busy", busy, 0);
    check("t7_zero_window_valid", out_valid, 0);
    check("t7_scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
